// File: rtl/vga_vram_scanner_pkg.sv
// Shared VGA 640x480@60 timing constants and VRAM bitmap geometry.
package vga_pkg;
  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int SCALE    = 5;
  localparam int IMG_W    = 128;
  localparam int IMG_H    = 96;
  localparam int ADDR_W   = 14;
  localparam int HC_W     = 10;
  localparam int VC_W     = 10;
endpackage

// File: rtl/vga_vram_scanner_if.sv
// VRAM read port and VGA connector signals of the scanner.
interface vga_vram_scanner_if;
  import vga_pkg::*;
  logic [ADDR_W-1:0] vram_address;
  logic              vram_red;
  logic              vram_green;
  logic              vram_blue;
  logic [3:0]        vga_red;
  logic [3:0]        vga_green;
  logic [3:0]        vga_blue;
  logic              vga_hsync;
  logic              vga_vsync;
  logic              frame_start;

  modport master (
    output vram_address, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
    input  vram_red, vram_green, vram_blue
  );
  modport slave (
    input  vram_address, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
    output vram_red, vram_green, vram_blue
  );
endinterface

// File: rtl/vga_vram_scanner_timing.sv
// Pixel-tick divider plus horizontal/vertical counters with raw phase decode.
module vga_timing_counter #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     tick,
  output logic                     line_end,
  output logic                     frame_end,
  output logic [vga_pkg::HC_W-1:0] hcount,
  output logic [vga_pkg::VC_W-1:0] vcount,
  output logic                     active,
  output logic                     hsync_raw,
  output logic                     vsync_raw
);
  import vga_pkg::*;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]  HS_START = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  VS_START = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [HC_W-1:0]  hcount_q, hcount_d;
  logic [VC_W-1:0]  vcount_q, vcount_d;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    line_end  = tick && (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (line_end) begin
      hcount_d = '0;
      vcount_d = frame_end ? '0 : vcount_q + 1'b1;
    end else if (tick) begin
      hcount_d = hcount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign active    = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign hsync_raw = !((hcount_q >= HS_START) && (hcount_q < HS_END));
  assign vsync_raw = !((vcount_q >= VS_START) && (vcount_q < VS_END));
endmodule

// File: rtl/vga_vram_scanner.sv
// VGA scanner: walks the scaled VRAM bitmap, drives the read address and
// registers colour/sync one pixel period behind the timing counters.
module vga_vram_scanner #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int SCALE    = vga_pkg::SCALE,
  parameter int IMG_W    = vga_pkg::IMG_W,
  parameter int IMG_H    = vga_pkg::IMG_H
) (
  input  logic                clk,
  input  logic                reset,
  vga_vram_scanner_if.master  bus
);
  import vga_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [HC_W-1:0]  H_ACT_LAST = HC_W'(H_ACTIVE - 1);
  localparam logic [VC_W-1:0]  V_ACT_LAST = VC_W'(V_ACTIVE - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SCALE - 1);

  logic            tick, line_end, frame_end, active, hsync_raw, vsync_raw;
  logic [HC_W-1:0] hcount;
  logic [VC_W-1:0] vcount;

  vga_timing_counter #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .tick(tick), .line_end(line_end), .frame_end(frame_end),
    .hcount(hcount), .vcount(vcount), .active(active),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw)
  );

  logic [SUB_W-1:0]  hsub_q, hsub_d, vsub_q, vsub_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

  always_comb begin
    hsub_d  = hsub_q;
    col_d   = col_q;
    vsub_d  = vsub_q;
    row_d   = row_q;
    addr_d  = addr_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    // Sub-pixel counters only step while the next pixel is still visible,
    // so col/row stay in range and the address holds through blanking.
    if (line_end) begin
      hsub_d = '0;
      col_d  = '0;
    end else if (tick && (hcount < H_ACT_LAST)) begin
      if (hsub_q == SUB_LAST) begin
        hsub_d = '0;
        col_d  = col_q + 1'b1;
      end else begin
        hsub_d = hsub_q + 1'b1;
      end
    end
    if (frame_end) begin
      vsub_d = '0;
      row_d  = '0;
    end else if (line_end && (vcount < V_ACT_LAST)) begin
      if (vsub_q == SUB_LAST) begin
        vsub_d = '0;
        row_d  = row_q + 1'b1;
      end else begin
        vsub_d = vsub_q + 1'b1;
      end
    end
    if (active) addr_d = ADDR_W'({row_q, col_q});
    // BRAM data for the current pixel has settled well before its closing tick.
    if (tick) begin
      red_d   = active ? {4{bus.vram_red}}   : 4'h0;
      green_d = active ? {4{bus.vram_green}} : 4'h0;
      blue_d  = active ? {4{bus.vram_blue}}  : 4'h0;
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
    end
    fs_d = tick && (hcount == '0) && (vcount == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsub_q  <= '0;
      col_q   <= '0;
      vsub_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      hsub_q  <= hsub_d;
      col_q   <= col_d;
      vsub_q  <= vsub_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.vram_address = addr_q;
  assign bus.vga_red      = red_q;
  assign bus.vga_green    = green_q;
  assign bus.vga_blue     = blue_q;
  assign bus.vga_hsync    = hsync_q;
  assign bus.vga_vsync    = vsync_q;
  assign bus.frame_start  = fs_q;
endmodule

// File: tb/tb_vga_vram_scanner.sv
// Bench: full-size scanner (first lines) plus a shrunken-timing scanner
// (whole frames, mid-frame reset), both checked every clock against a pixel model.
module tb_vga_vram_scanner;
  typedef struct packed {logic [3:0] r; logic [3:0] g; logic [3:0] b; logic hs; logic vs; logic fs;} out_t;
  typedef struct packed {int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb; int iw;} cfg_t;
  localparam out_t RST_OUT = '{r:4'h0, g:4'h0, b:4'h0, hs:1'b1, vs:1'b1, fs:1'b0};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vga_vram_scanner_if bus_a();
  vga_vram_scanner_if bus_b();

  vga_vram_scanner u_dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  vga_vram_scanner #(
    .CLK_DIV(4), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3), .SCALE(5), .IMG_W(8), .IMG_H(6)
  ) u_dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  function automatic cfg_t get_cfg(input int c);
    cfg_t g;
    if (c == 0) g = '{640, 16, 96, 48, 480, 10, 2, 33, 128};
    else        g = '{40, 4, 8, 4, 30, 2, 2, 3, 8};
    return g;
  endfunction

  // VRAM contents: A is tied red=1/green=0/blue=1, B returns address parity bits.
  function automatic logic [2:0] vram_fn(input int c, input int a);
    logic [13:0] aa;
    aa = a[13:0];
    if (c == 0) return 3'b101;
    return {^aa, aa[0], aa[1]};
  endfunction

  assign bus_a.vram_red   = 1'b1;
  assign bus_a.vram_green = 1'b0;
  assign bus_a.vram_blue  = 1'b1;
  always @(posedge clk)
    {bus_b.vram_red, bus_b.vram_green, bus_b.vram_blue} <= vram_fn(1, int'(bus_b.vram_address));

  function automatic bit pix_active(input int c, input int p);
    cfg_t g = get_cfg(c);
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    return ((p % ht) < g.ha) && (((p / ht) % vt) < g.va);
  endfunction

  function automatic int pix_addr(input int c, input int p);
    cfg_t g = get_cfg(c);
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    return (((p / ht) % vt) / 5) * g.iw + (p % ht) / 5;
  endfunction

  function automatic out_t model_pix(input int c, input int p);
    cfg_t g = get_cfg(c);
    int ht = g.ha + g.hf + g.hs + g.hb;
    int vt = g.va + g.vf + g.vs + g.vb;
    int h = p % ht;
    int v = (p / ht) % vt;
    bit act = pix_active(c, p);
    logic [2:0] d = vram_fn(c, pix_addr(c, p));
    out_t m;
    m.r  = (act && d[2]) ? 4'hF : 4'h0;
    m.g  = (act && d[1]) ? 4'hF : 4'h0;
    m.b  = (act && d[0]) ? 4'hF : 4'h0;
    m.hs = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs));
    m.vs = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs));
    m.fs = (h == 0) && (v == 0);
    return m;
  endfunction

  out_t q_a[$];
  out_t q_b[$];
  out_t cur_a, cur_b;
  int   ea_a, ea_b;
  int   n_a, n_b;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  task automatic chk_out(input string tag, input out_t obs, input out_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n = clocks since the reset-sampling edge; outputs show pixel n/4-1,
  // address shows the pixel the counters held one clock earlier.
  task automatic check(input int c, input int n);
    out_t obs, cur;
    int ea, addr_o;
    if (c == 0) begin
      obs = {bus_a.vga_red, bus_a.vga_green, bus_a.vga_blue, bus_a.vga_hsync, bus_a.vga_vsync, bus_a.frame_start};
      addr_o = int'(bus_a.vram_address);
      cur = cur_a; ea = ea_a;
    end else begin
      obs = {bus_b.vga_red, bus_b.vga_green, bus_b.vga_blue, bus_b.vga_hsync, bus_b.vga_vsync, bus_b.frame_start};
      addr_o = int'(bus_b.vram_address);
      cur = cur_b; ea = ea_b;
    end
    if (n < 4) cur = RST_OUT;
    else if (n % 4 == 0) begin
      if (c == 0) begin if (q_a.size() > 0) cur = q_a.pop_front(); end
      else begin if (q_b.size() > 0) cur = q_b.pop_front(); end
    end else cur.fs = 1'b0;
    if (n % 4 == 0) begin
      if (c == 0) q_a.push_back(model_pix(0, n / 4));
      else        q_b.push_back(model_pix(1, n / 4));
    end
    if (n == 0) ea = 0;
    else if (pix_active(c, (n - 1) / 4)) ea = pix_addr(c, (n - 1) / 4);
    chk_out(c == 0 ? "out_a" : "out_b", obs, cur);
    chk_int(c == 0 ? "addr_a" : "addr_b", addr_o, ea);
    if (c == 0) begin cur_a = cur; ea_a = ea; end
    else begin cur_b = cur; ea_b = ea; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_a++;
    n_b++;
    check(0, n_a);
    check(1, n_b);
    if (n_a == 4)           chk_int("fs_first_a", int'(bus_a.frame_start), 1);
    if (n_a == 4*5+2)       chk_int("addr_px5", int'(bus_a.vram_address), 1);
    if (n_a == 4*635+2)     chk_int("addr_px635", int'(bus_a.vram_address), 127);
    if (n_a == 4*4000+2)    chk_int("addr_line5", int'(bus_a.vram_address), 128);
    if (n_a == 656*4+3)     chk_int("hsync_pre_a", int'(bus_a.vga_hsync), 1);
    if (n_a == 656*4+4)     chk_int("hsync_fall_a", int'(bus_a.vga_hsync), 0);
    if (n_a == 656*4+4+384) chk_int("hsync_rise_a", int'(bus_a.vga_hsync), 1);
    if (n_b == 4*(29*56+39)+2) chk_int("addr_last_b", int'(bus_b.vram_address), 47);
    if (n_b == 44*4+3)      chk_int("hsync_pre_b", int'(bus_b.vga_hsync), 1);
    if (n_b == 44*4+4)      chk_int("hsync_fall_b", int'(bus_b.vga_hsync), 0);
    if (n_b == 8288+4)      chk_int("fs_frame2_b", int'(bus_b.frame_start), 1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    n_a = 0;
    n_b = 0;
    check(0, 0);
    check(1, 0);
    // Second frame of B, counters at h=30 v=20.
    while (n_b < 8288 + 4*(20*56+30) + 1) step();
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    n_a++;
    n_b = 0;
    q_b.delete();
    check(0, n_a);
    check(1, 0);
    chk_int("mid_rst_hsync", int'(bus_b.vga_hsync), 1);
    repeat (9600) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
